// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C-style responder (camera-side model).
// Oversamples SIOC/SIOD on clk, decodes START/STOP, the device ID, a register
// address and write data. Writes come out as a one-cycle strobe. Reads are served
// from an external register bank addressed by rd_addr.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   SIOC_in, SIOD_in   asynchronous bus pin levels
//   SIOD_oe            1 = pull SIOD low (ACK or read bit of value 0)
//   wr_valid/addr/data one-cycle register write strobe with address and data
//   rd_addr, rd_data   register pointer and the bank contents at that pointer
//   busy               high whenever the state is not IDLE
module sccb_target #(
  parameter logic [7:0] DEVICE_ADDR = 8'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SIOC_in,
  input  logic       SIOD_in,
  output logic       SIOD_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ID, ACK_ID, REG, ACK_REG, WDATA, ACK_W, RDATA, MACK, IGNORE
  } state_t;

  state_t     state;
  logic [7:0] shift_reg;
  logic [3:0] bit_cnt;
  logic       rw;          // latched R/W bit of the ID byte
  logic       ack_phase;   // ACK states: SIOD is being pulled; MACK: master acked
  logic [7:0] pointer;

  // Synchronizers and history stage. They only track pin levels, so they are
  // deliberately left out of reset: forcing them to a fixed level could make a
  // pin that is already low look like a fresh START right after reset.
  logic sioc_s1, sioc_s2, sioc_d;
  logic siod_s1, siod_s2, siod_d;

  always_ff @(posedge clk) begin
    sioc_s1 <= SIOC_in;
    sioc_s2 <= sioc_s1;
    sioc_d  <= sioc_s2;
    siod_s1 <= SIOD_in;
    siod_s2 <= siod_s1;
    siod_d  <= siod_s2;
  end

  logic sioc_rise, sioc_fall, start_det, stop_det;
  logic [7:0] byte_in;

  assign sioc_rise = sioc_s2 & ~sioc_d;
  assign sioc_fall = ~sioc_s2 & sioc_d;
  assign start_det = sioc_s2 & sioc_d & siod_d & ~siod_s2;
  assign stop_det  = sioc_s2 & sioc_d & ~siod_d & siod_s2;
  // Byte as it stands once the bit now being sampled is shifted in.
  assign byte_in   = {shift_reg[6:0], siod_s2};

  assign rd_addr = pointer;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= 8'h00;
      bit_cnt   <= 4'd0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      pointer   <= 8'h00;
      SIOD_oe   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state     <= ID;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        SIOD_oe   <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        ack_phase <= 1'b0;
        SIOD_oe   <= 1'b0;
      end else begin
        case (state)
          ID, REG, WDATA: begin
            if (sioc_rise) begin
              shift_reg <= byte_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                if (state == ID) begin
                  rw    <= byte_in[0];
                  state <= (byte_in[7:1] == DEVICE_ADDR[7:1]) ? ACK_ID : IGNORE;
                end else if (state == REG) begin
                  pointer <= byte_in;
                  state   <= ACK_REG;
                end else begin
                  wr_valid <= 1'b1;
                  wr_addr  <= pointer;
                  wr_data  <= byte_in;
                  state    <= ACK_W;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ACK_ID, ACK_REG, ACK_W: begin
            // First fall after the byte: pull low for the 9th bit.
            // Second fall: release and move on.
            if (sioc_fall) begin
              if (!ack_phase) begin
                SIOD_oe   <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 4'd0;
                SIOD_oe   <= 1'b0;
                if (state == ACK_ID) begin
                  if (rw) begin
                    // Read: the release cycle already drives the first data bit.
                    shift_reg <= rd_data;
                    SIOD_oe   <= ~rd_data[7];
                    state     <= RDATA;
                  end else begin
                    state <= REG;
                  end
                end else if (state == ACK_REG) begin
                  state <= WDATA;
                end else begin
                  pointer <= pointer + 8'd1;
                  state   <= WDATA;
                end
              end
            end
          end

          RDATA: begin
            if (sioc_fall) begin
              if (bit_cnt == 4'd7) begin
                SIOD_oe   <= 1'b0;
                ack_phase <= 1'b0;
                state     <= MACK;
              end else begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                SIOD_oe   <= ~shift_reg[6];
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end

          MACK: begin
            if (sioc_rise && !ack_phase) begin
              if (!siod_s2) begin
                pointer   <= pointer + 8'd1;
                ack_phase <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end else if (sioc_fall && ack_phase) begin
              // rd_data already reflects the incremented pointer here.
              shift_reg <= rd_data;
              SIOD_oe   <= ~rd_data[7];
              bit_cnt   <= 4'd0;
              ack_phase <= 1'b0;
              state     <= RDATA;
            end
          end

          IGNORE: SIOD_oe <= 1'b0;

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Testbench for sccb_target: a bus master drives SIOC/SIOD (wired-AND with the
// target's pulldown), a register bank answers rd_addr, and a transaction-level
// model (pointer + register array + expected-write queue) predicts ACKs,
// read bytes, write strobes and the final pointer.
module tb_sccb_target;

  localparam int Q = 5;   // clk cycles per quarter SIOC period (20x oversampling)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sioc = 1'b1;
  logic       siod_m = 1'b1;
  logic       SIOD_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       siod_pin;

  logic [7:0] dut_bank [256];
  logic [7:0] model_bank [256];
  logic [7:0] model_ptr = 8'h00;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #20 clk = ~clk;

  assign siod_pin = siod_m & ~SIOD_oe;
  assign rd_data  = dut_bank[rd_addr];

  sccb_target #(.DEVICE_ADDR(8'h42)) dut (
    .clk(clk), .reset(reset), .SIOC_in(sioc), .SIOD_in(siod_pin),
    .SIOD_oe(SIOD_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  // Write monitor: the bench's bank takes every strobed write.
  always @(negedge clk) begin
    if (!reset && wr_valid) begin
      got_q.push_back({wr_addr, wr_data});
      dut_bank[wr_addr] = wr_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qdelay();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    siod_m = 1'b1; qdelay();
    sioc = 1'b1;   qdelay();
    siod_m = 1'b0; qdelay();
    sioc = 1'b0;   qdelay();
  endtask

  task automatic bus_stop();
    siod_m = 1'b0; qdelay();
    sioc = 1'b1;   qdelay();
    siod_m = 1'b1; qdelay();
    qdelay();
  endtask

  task automatic send_bit(input logic b, output logic pin);
    siod_m = b;  qdelay();
    sioc = 1'b1; qdelay();
    pin = siod_pin;
    qdelay();
    sioc = 1'b0; qdelay();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic pin;
    for (int i = 7; i >= 0; i--) send_bit(d[i], pin);
    send_bit(1'b1, pin);
    ack = ~pin;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic pin;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, pin);
      d[i] = pin;
    end
    send_bit(~master_ack, pin);
  endtask

  task automatic finish_txn(input string name);
    int n;
    repeat (8) @(posedge clk);
    #1;
    check_eq({name, "_busy"}, busy, 1'b0);
    check_eq({name, "_ptr"}, rd_addr, model_ptr);
    check_eq({name, "_wr_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({name, "_wr"}, got_q[i], exp_q[i]);
    $display("txn %s: %0d writes, pointer %02h", name, exp_q.size(), model_ptr);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input string name, input logic [7:0] id_in, input logic [7:0] regad,
                          input int nd, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] id;
    logic [7:0] dv [3];
    logic ack, match;
    id = {id_in[7:1], 1'b0};
    match = (id == 8'h42);
    dv[0] = d0; dv[1] = d1; dv[2] = d2;
    bus_start();
    send_byte(id, ack);
    check_eq({name, "_id_ack"}, ack, match);
    send_byte(regad, ack);
    check_eq({name, "_reg_ack"}, ack, match);
    if (match) model_ptr = regad;
    for (int i = 0; i < nd; i++) begin
      send_byte(dv[i], ack);
      check_eq({name, "_dat_ack"}, ack, match);
      if (match) begin
        exp_q.push_back({model_ptr, dv[i]});
        model_bank[model_ptr] = dv[i];
        model_ptr = model_ptr + 8'd1;
      end
    end
    bus_stop();
    finish_txn(name);
  endtask

  task automatic do_read(input string name, input logic [7:0] id_in, input int nb);
    logic [7:0] id, got;
    logic ack, match;
    id = {id_in[7:1], 1'b1};
    match = (id == 8'h43);
    bus_start();
    send_byte(id, ack);
    check_eq({name, "_id_ack"}, ack, match);
    for (int i = 0; i < nb; i++) begin
      recv_byte(i != nb - 1, got);
      check_eq({name, "_rd_byte"}, got, match ? model_bank[model_ptr] : 8'hFF);
      if (match && i != nb - 1) model_ptr = model_ptr + 8'd1;
    end
    bus_stop();
    finish_txn(name);
  endtask

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack, pin;
    for (int i = 0; i < 256; i++) begin
      dut_bank[i]   = 8'($urandom);
      model_bank[i] = dut_bank[i];
    end
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_oe", SIOD_oe, 1'b0);
    check_eq("rst_wr_valid", wr_valid, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 8'h00);
    check_eq("rst_wr_data", wr_data, 8'h00);
    check_eq("rst_rd_addr", rd_addr, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    qdelay();

    do_write("basic", 8'h42, 8'h12, 1, 8'h80, 8'h00, 8'h00);
    do_write("wrong_id", 8'h60, 8'h12, 1, 8'h55, 8'h00, 8'h00);
    do_write("two_phase", 8'h42, 8'h0A, 0, 8'h00, 8'h00, 8'h00);
    dut_bank[8'h0A] = 8'h76;
    model_bank[8'h0A] = 8'h76;
    do_read("read_na", 8'h43, 1);
    do_write("burst_wrap", 8'h42, 8'hFF, 2, 8'h11, 8'h22, 8'h00);

    // Repeated START after 4 bits of the register byte.
    bus_start();
    send_byte(8'h42, ack);
    check_eq("rs_id_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(i[0], pin);
    do_write("rep_start", 8'h42, 8'h05, 1, 8'h33, 8'h00, 8'h00);

    // Reset while the target is acknowledging the register byte.
    bus_start();
    send_byte(8'h42, ack);
    for (int i = 7; i >= 0; i--) send_bit(i[0], pin);
    check_eq("ackreg_oe", SIOD_oe, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstmid_oe", SIOD_oe, 1'b0);
    check_eq("rstmid_busy", busy, 1'b0);
    reset = 1'b0;
    model_ptr = 8'h00;
    send_bit(1'b1, pin);
    send_byte(8'h99, ack);
    check_eq("rstmid_dat_ack", ack, 1'b0);
    bus_stop();
    finish_txn("reset_mid");

    for (int t = 0; t < 30; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        do_write("rnd_wr", (r == 0) ? 8'($urandom) : 8'h42, 8'($urandom),
                 $urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        do_read("rnd_rd", (r == 5) ? 8'($urandom) : 8'h43, $urandom_range(1, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
